// File: rtl/gshare_pht.sv
// gshare pattern history table with a non-speculative global history register.
// Fetch hashes the PC with the history to pick a 2-bit counter and predicts
// from its MSB; the resolve stage reads the counter back at the captured index,
// writes the next state supplied by the external update controller, and shifts
// the actual outcome into the history.
module gshare_pht #(
   parameter int IDX_BITS  = 8,
   parameter int HIST_BITS = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [15:0]          pred_pc,
   output logic                 pred_taken,
   output logic [IDX_BITS-1:0]  pred_idx,
   input  logic                 upd_valid,
   input  logic [IDX_BITS-1:0]  upd_idx,
   input  logic                 upd_taken,
   output logic [1:0]           upd_state,
   input  logic [1:0]           upd_next_state,
   output logic [HIST_BITS-1:0] ghr
);

   localparam int ENTRIES = 1 << IDX_BITS;

   logic [1:0]           pht_q [ENTRIES];
   logic [1:0]           pht_d [ENTRIES];
   logic [HIST_BITS-1:0] ghr_q;
   logic [HIST_BITS-1:0] ghr_d;
   logic [HIST_BITS-1:0] ghr_shift;
   logic [IDX_BITS-1:0]  hist_ext;

   // History zero-extended to index width; a shorter history only folds into the low index bits.
   always_comb begin
      hist_ext                  = '0;
      hist_ext[HIST_BITS-1:0]   = ghr_q;
   end

   // Predict and read-back paths are purely combinational from pre-edge state, so a
   // same-cycle update to the predicted entry is not bypassed.
   assign pred_idx   = pred_pc[IDX_BITS:1] ^ hist_ext;
   assign pred_taken = pht_q[pred_idx][1];
   assign upd_state  = pht_q[upd_idx];
   assign ghr        = ghr_q;

   // Newest outcome enters at bit 0; the oldest bit falls off the top.
   generate
      if (HIST_BITS == 1) begin : g_hist_one
         assign ghr_shift = upd_taken;
      end else begin : g_hist_many
         assign ghr_shift = {ghr_q[HIST_BITS-2:0], upd_taken};
      end
   endgenerate

   // PC bit 0 is always zero for word-aligned fetch and the upper bits do not feed the hash.
   generate
      if (IDX_BITS < 15) begin : g_pc_upper
         logic unused_pc_bits;
         assign unused_pc_bits = ^{pred_pc[15:IDX_BITS+1], pred_pc[0]};
      end else begin : g_pc_lsb
         logic unused_pc_bits;
         assign unused_pc_bits = pred_pc[0];
      end
   endgenerate

   // Next-state: write the controller's value verbatim and shift history on a resolved branch.
   always_comb begin
      pht_d = pht_q;
      ghr_d = ghr_q;
      if (upd_valid) begin
         pht_d[upd_idx] = upd_next_state;
         ghr_d          = ghr_shift;
      end
   end

   // State registers; reset wins over any same-cycle update and restores weak not-taken.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < ENTRIES; i++) begin
            pht_q[i] <= 2'b01;
         end
         ghr_q <= '0;
      end else begin
         pht_q <= pht_d;
         ghr_q <= ghr_d;
      end
   end

endmodule
